// File: rtl/map_rom_arbiter.sv
// -----------------------------------------------------------------------------
// map_rom_arbiter
//
// Shares the single-port map tile ROM between the VGA pixel fetch path and
// game-logic queries (collision / portal checks). The (x,y) pair of the slot
// owner is turned into a linear ROM address with a bounds check. The address
// and every result output are registered.
//
// VGA has priority. A logic request that arrives while VGA is fetching waits.
// After STARVE_MAX edges it takes one VGA slot, so logic is always served
// during active video.
//
// Timing: the slot owner and rom_addr are set at edge N. The ROM answers
// combinationally on rom_data, and the result is captured at edge N+1.
//
// Optional feature:
//   MAP_ARB_STATS_EN  adds output steal_cnt[15:0], a saturating count of
//                     VGA slots taken by logic requests.
//
// Ports
//   clk        in   system clock
//   rstn       in   asynchronous active-low reset
//   vga_en     in   VGA fetch request this cycle
//   vga_x/y    in   VGA column (10b) / row (9b)
//   vga_data   out  registered pixel data
//   vga_valid  out  vga_data updated from a VGA fetch this cycle
//   logic_req  in   logic query request, held with stable x/y until ack
//   logic_x/y  in   query column (10b) / row (9b)
//   logic_ack  out  one-cycle pulse, logic_data valid while high
//   logic_data out  query result, held until the next ack
//   rom_addr   out  registered ROM address
//   rom_data   in   ROM word, combinational from rom_addr
//   steal_cnt  out  (MAP_ARB_STATS_EN only) count of stolen VGA slots
//
// Logic FSM
//   state   | meaning
//   IDLE    | no request outstanding
//   WAIT    | request pending behind VGA, cnt = edges waited
//   ISSUED  | slot granted, ROM address out, result arrives next edge
//   ACK     | logic_ack high for this cycle, requests ignored
// -----------------------------------------------------------------------------
module map_rom_arbiter #(
    parameter int                MAP_W      = 100,
    parameter int                MAP_H      = 100,
    parameter int                ADDR_W     = 14,
    parameter int                DATA_W     = 12,
    parameter logic [DATA_W-1:0] OOB_VALUE  = 12'h000,
    parameter int                STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              vga_en,
    input  logic [9:0]        vga_x,
    input  logic [8:0]        vga_y,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              logic_req,
    input  logic [9:0]        logic_x,
    input  logic [8:0]        logic_y,
    output logic              logic_ack,
    output logic [DATA_W-1:0] logic_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
`ifdef MAP_ARB_STATS_EN
    ,
    output logic [15:0]       steal_cnt
`endif
);

    localparam int         CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [9:0] MAP_W_X = 10'(MAP_W);
    localparam logic [8:0] MAP_H_Y = 9'(MAP_H);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ISSUED = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    // Owner tags for the fetch currently on the ROM bus.
    logic              p_vga;
    logic              p_oob;

    logic              grant;
    logic              steal;
    logic              vga_own;
    logic [9:0]        sel_x;
    logic [8:0]        sel_y;
    logic              oob;
    logic [ADDR_W-1:0] addr_calc;
    logic [DATA_W-1:0] rd_word;

    // A grant from WAIT while VGA is still asking means this edge's VGA slot
    // is stolen. That can only happen once the wait count reaches STARVE_MAX.
    always_comb begin
        grant = 1'b0;
        if (logic_req) begin
            if (state == S_IDLE)
                grant = !vga_en;
            else if (state == S_WAIT)
                grant = !vga_en || (cnt == CNT_W'(STARVE_MAX));
        end
        steal   = grant && vga_en;
        vga_own = vga_en && !steal;
    end

    always_comb begin
        sel_x     = vga_own ? vga_x : logic_x;
        sel_y     = vga_own ? vga_y : logic_y;
        oob       = (sel_x >= MAP_W_X) || (sel_y >= MAP_H_Y);
        // In-bounds coordinates keep the product below MAP_W*MAP_H, so
        // computing at ADDR_W bits cannot overflow.
        addr_calc = ADDR_W'(sel_y) * ADDR_W'(MAP_W) + ADDR_W'(sel_x);
        rd_word   = p_oob ? OOB_VALUE : rom_data;
    end

    // Address issue and result capture for the VGA path.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rom_addr  <= '0;
            p_vga     <= 1'b0;
            p_oob     <= 1'b0;
            vga_valid <= 1'b0;
            vga_data  <= '0;
        end else begin
            p_vga <= vga_own;
            if (vga_own || grant) begin
                rom_addr <= oob ? '0 : addr_calc;
                p_oob    <= oob;
            end
            vga_valid <= p_vga;
            if (p_vga)
                vga_data <= rd_word;
        end
    end

    // Logic request FSM. The result is loaded when leaving ISSUED, because the
    // granted address went out on the previous edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            logic_ack  <= 1'b0;
            logic_data <= '0;
        end else begin
            logic_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (logic_req) begin
                        if (!vga_en) begin
                            state <= S_ISSUED;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!logic_req) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (grant) begin
                        state <= S_ISSUED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ISSUED: begin
                    state      <= S_ACK;
                    logic_ack  <= 1'b1;
                    logic_data <= rd_word;
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef MAP_ARB_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            steal_cnt <= '0;
        else if (steal && (steal_cnt != 16'hFFFF))
            steal_cnt <= steal_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_map_rom_arbiter.sv
module tb_map_rom_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        vga_en;
    logic [9:0]  vga_x;
    logic [8:0]  vga_y;
    logic [11:0] vga_data;
    logic        vga_valid;
    logic        logic_req;
    logic [9:0]  logic_x;
    logic [8:0]  logic_y;
    logic        logic_ack;
    logic [11:0] logic_data;
    logic [13:0] rom_addr;
    logic [11:0] rom_data;
`ifdef MAP_ARB_STATS_EN
    logic [15:0] steal_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    map_rom_arbiter dut (
        .clk        (clk),
        .rstn       (rstn),
        .vga_en     (vga_en),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_data   (vga_data),
        .vga_valid  (vga_valid),
        .logic_req  (logic_req),
        .logic_x    (logic_x),
        .logic_y    (logic_y),
        .logic_ack  (logic_ack),
        .logic_data (logic_data),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data)
`ifdef MAP_ARB_STATS_EN
        ,
        .steal_cnt  (steal_cnt)
`endif
    );

    // ROM contents model: distinct pattern, ROM[0] differs from the OOB value.
    function automatic logic [11:0] rom_fn(input logic [13:0] a);
        int v;
        v = int'(a) * 13 + 32'h2A5;
        return v[11:0];
    endfunction

    always_comb rom_data = rom_fn(rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Power-on reset state.
        #1;
        checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL por_rom_addr got=%0d exp=0", rom_addr); end
        checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL por_vga_valid got=%b exp=0", vga_valid); end
        checks++; if (logic_ack !== 1'b0) begin errors++; $display("FAIL por_logic_ack got=%b exp=0", logic_ack); end
        #10 rstn = 1'b1;
        tick();
        // Traffic, then asynchronous reset mid-cycle.
        vga_en = 1'b1; vga_x = 10'd7; vga_y = 9'd9;
        tick(); tick(); tick();
        #2 rstn = 1'b0;
        #1;
        checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL rst_rom_addr got=%0d exp=0", rom_addr); end
        checks++; if (vga_data !== 12'd0) begin errors++; $display("FAIL rst_vga_data got=%h exp=000", vga_data); end
        checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL rst_vga_valid got=%b exp=0", vga_valid); end
        checks++; if (logic_ack !== 1'b0 || logic_data !== 12'd0) begin errors++; $display("FAIL rst_logic got ack=%b data=%h exp 0/000", logic_ack, logic_data); end
        vga_en = 1'b0;
        #3 rstn = 1'b1;
        tick();
        checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid got=%b exp=0", vga_valid); end
    endtask

    task automatic test_vga_stream();
        logic [13:0] prev;
        vga_en = 1'b1; vga_x = 10'd3; vga_y = 9'd2;
        tick();
        checks++; if (rom_addr !== 14'd203) begin errors++; $display("FAIL vga_addr got=%0d exp=203", rom_addr); end
        checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL vga_valid_e0 got=%b exp=0", vga_valid); end
        vga_x = 10'd0; vga_y = 9'd5;
        tick();
        checks++; if (vga_valid !== 1'b1 || vga_data !== rom_fn(14'd203)) begin errors++; $display("FAIL vga_data_203 got=%b/%h exp=1/%h", vga_valid, vga_data, rom_fn(14'd203)); end
        prev = 14'd500;
        for (int i = 1; i < 100; i++) begin
            vga_x = 10'(i);
            tick();
            checks++;
            if (vga_valid !== 1'b1 || vga_data !== rom_fn(prev) || rom_addr !== 14'(500 + i)) begin
                errors++;
                $display("FAIL vga_stream x=%0d got=%b/%h/%0d exp=1/%h/%0d", i, vga_valid, vga_data, rom_addr, rom_fn(prev), 500 + i);
            end
            prev = 14'(500 + i);
        end
        vga_en = 1'b0;
        tick();
        checks++; if (vga_valid !== 1'b1 || vga_data !== rom_fn(14'd599)) begin errors++; $display("FAIL vga_last got=%b/%h exp=1/%h", vga_valid, vga_data, rom_fn(14'd599)); end
        tick();
        checks++; if (vga_valid !== 1'b0 || vga_data !== rom_fn(14'd599)) begin errors++; $display("FAIL vga_hold got=%b/%h exp=0/%h", vga_valid, vga_data, rom_fn(14'd599)); end
    endtask

    task automatic test_oob();
        vga_en = 1'b1; vga_x = 10'd100; vga_y = 9'd0;
        tick();
        checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL oob_x_addr got=%0d exp=0", rom_addr); end
        vga_x = 10'd99; vga_y = 9'd100;
        tick();
        checks++; if (vga_valid !== 1'b1 || vga_data !== 12'h000) begin errors++; $display("FAIL oob_x_data got=%b/%h exp=1/000", vga_valid, vga_data); end
        checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL oob_y_addr got=%0d exp=0", rom_addr); end
        vga_x = 10'd99; vga_y = 9'd99;
        tick();
        checks++; if (vga_data !== 12'h000) begin errors++; $display("FAIL oob_y_data got=%h exp=000", vga_data); end
        checks++; if (rom_addr !== 14'd9999) begin errors++; $display("FAIL corner_addr got=%0d exp=9999", rom_addr); end
        vga_en = 1'b0;
        tick();
        checks++; if (vga_data !== rom_fn(14'd9999)) begin errors++; $display("FAIL corner_data got=%h exp=%h", vga_data, rom_fn(14'd9999)); end
        tick();
    endtask

    task automatic test_logic_query();
        vga_en = 1'b0;
        logic_req = 1'b1; logic_x = 10'd5; logic_y = 9'd1;
        tick();
        checks++; if (rom_addr !== 14'd105 || logic_ack !== 1'b0) begin errors++; $display("FAIL lq_addr got=%0d/%b exp=105/0", rom_addr, logic_ack); end
        tick();
        checks++; if (logic_ack !== 1'b1 || logic_data !== rom_fn(14'd105)) begin errors++; $display("FAIL lq_ack got=%b/%h exp=1/%h", logic_ack, logic_data, rom_fn(14'd105)); end
        checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL lq_no_vga got=%b exp=0", vga_valid); end
        logic_req = 1'b0;
        tick();
        checks++; if (logic_ack !== 1'b0 || logic_data !== rom_fn(14'd105)) begin errors++; $display("FAIL lq_ack_drop got=%b/%h exp=0/%h", logic_ack, logic_data, rom_fn(14'd105)); end
    endtask

    task automatic test_starvation();
        vga_en = 1'b1; vga_x = 10'd10; vga_y = 9'd3;
        logic_req = 1'b1; logic_x = 10'd7; logic_y = 9'd4;
        for (int e = 0; e < 8; e++) begin
            tick();
            checks++;
            if (logic_ack !== 1'b0 || rom_addr !== 14'd310) begin
                errors++;
                $display("FAIL starve_wait e=%0d got ack=%b addr=%0d exp 0/310", e, logic_ack, rom_addr);
            end
        end
        tick();
        checks++; if (rom_addr !== 14'd407) begin errors++; $display("FAIL starve_grant_addr got=%0d exp=407", rom_addr); end
        checks++; if (vga_valid !== 1'b1 || vga_data !== rom_fn(14'd310)) begin errors++; $display("FAIL starve_pre got=%b/%h exp=1/%h", vga_valid, vga_data, rom_fn(14'd310)); end
        tick();
        checks++; if (logic_ack !== 1'b1 || logic_data !== rom_fn(14'd407)) begin errors++; $display("FAIL starve_ack got=%b/%h exp=1/%h", logic_ack, logic_data, rom_fn(14'd407)); end
        checks++; if (vga_valid !== 1'b0 || vga_data !== rom_fn(14'd310)) begin errors++; $display("FAIL starve_gap got=%b/%h exp=0/%h", vga_valid, vga_data, rom_fn(14'd310)); end
        checks++; if (rom_addr !== 14'd310) begin errors++; $display("FAIL starve_vga_back got=%0d exp=310", rom_addr); end
`ifdef MAP_ARB_STATS_EN
        checks++; if (steal_cnt !== 16'd1) begin errors++; $display("FAIL steal_cnt got=%0d exp=1", steal_cnt); end
`endif
        logic_req = 1'b0;
        tick();
        checks++; if (vga_valid !== 1'b1 || logic_ack !== 1'b0) begin errors++; $display("FAIL starve_after got=%b/%b exp=1/0", vga_valid, logic_ack); end
        vga_en = 1'b0;
        tick(); tick();
    endtask

    task automatic test_abandon();
        vga_en = 1'b1; vga_x = 10'd1; vga_y = 9'd1;
        logic_req = 1'b1; logic_x = 10'd2; logic_y = 9'd2;
        tick(); tick();
        logic_req = 1'b0;
        for (int e = 0; e < 12; e++) begin
            tick();
            checks++;
            if (logic_ack !== 1'b0 || vga_valid !== 1'b1 || rom_addr !== 14'd101) begin
                errors++;
                $display("FAIL abandon e=%0d got ack=%b valid=%b addr=%0d exp 0/1/101", e, logic_ack, vga_valid, rom_addr);
            end
        end
        vga_en = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_inflight();
        vga_en = 1'b0;
        logic_req = 1'b1; logic_x = 10'd5; logic_y = 9'd1;
        tick();
        checks++; if (rom_addr !== 14'd105) begin errors++; $display("FAIL rif_addr got=%0d exp=105", rom_addr); end
        #1 rstn = 1'b0;
        logic_req = 1'b0;
        #1;
        checks++; if (rom_addr !== 14'd0 || logic_data !== 12'd0) begin errors++; $display("FAIL rif_cleared got=%0d/%h exp=0/000", rom_addr, logic_data); end
        #2 rstn = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if (logic_ack !== 1'b0) begin errors++; $display("FAIL rif_no_ack e=%0d got=%b exp=0", e, logic_ack); end
        end
        logic_req = 1'b1;
        tick();
        checks++; if (rom_addr !== 14'd105) begin errors++; $display("FAIL rif_reissue_addr got=%0d exp=105", rom_addr); end
        tick();
        checks++; if (logic_ack !== 1'b1 || logic_data !== rom_fn(14'd105)) begin errors++; $display("FAIL rif_reissue_ack got=%b/%h exp=1/%h", logic_ack, logic_data, rom_fn(14'd105)); end
        logic_req = 1'b0;
        tick();
        checks++; if (logic_ack !== 1'b0) begin errors++; $display("FAIL rif_ack_drop got=%b exp=0", logic_ack); end
    endtask

    initial begin
        rstn = 1'b0;
        vga_en = 1'b0; vga_x = '0; vga_y = '0;
        logic_req = 1'b0; logic_x = '0; logic_y = '0;
        test_reset();
        test_vga_stream();
        test_oob();
        test_logic_query();
        test_starvation();
        test_abandon();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
